// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned NumRegsDefault     = 32;
  localparam int unsigned RegIdxWDefault     = 5;
  localparam int unsigned PcWDefault         = 32;
  localparam int unsigned CntWDefault        = 2;
  localparam int unsigned FlushCyclesDefault = 1;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StMemWait
  } state_e;

  // Field order is the order the control bundle is packed onto the stage buses.
  typedef struct packed {
    logic fe_stall;
    logic de_stall;
    logic agex_stall;
    logic de_bubble;
    logic fe_flush;
    logic de_flush;
    logic pc_redirect;
    logic data_hazard;
    logic control_hazard;
  } ctrl_t;

  localparam int unsigned CtrlWidth = $bits(ctrl_t);

endpackage

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write counters; x0 is hardwired to zero.
module reg_scoreboard #(
  parameter int unsigned NumRegs = 32,
  parameter int unsigned RegIdxW = 5,
  parameter int unsigned CntW    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_en,
  input  logic [RegIdxW-1:0] inc_idx,
  input  logic               dec_en,
  input  logic [RegIdxW-1:0] dec_idx,
  input  logic [RegIdxW-1:0] rs1_idx,
  input  logic [RegIdxW-1:0] rs2_idx,
  input  logic [RegIdxW-1:0] rd_idx,
  output logic [CntW-1:0]    rs1_cnt,
  output logic [CntW-1:0]    rs2_cnt,
  output logic [CntW-1:0]    rd_cnt,
  output logic [NumRegs-1:0] busy_mask
);

  localparam logic [CntW-1:0] CntMax = '1;

  logic [CntW-1:0]    pend_q [NumRegs];
  logic [CntW-1:0]    pend_d [NumRegs];
  logic [NumRegs-1:0] inc_hit;
  logic [NumRegs-1:0] dec_hit;

  assign inc_hit = inc_en ? (NumRegs'(1) << inc_idx) : '0;
  assign dec_hit = dec_en ? (NumRegs'(1) << dec_idx) : '0;

  // Simultaneous inc and dec on one register cancel; dec at zero holds.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      pend_d[i] = pend_q[i];
      if (i == 0) begin
        pend_d[i] = '0;
      end else if (inc_hit[i] && !dec_hit[i] && pend_q[i] != CntMax) begin
        pend_d[i] = pend_q[i] + 1'b1;
      end else if (dec_hit[i] && !inc_hit[i] && pend_q[i] != '0) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      busy_mask[i] = |pend_q[i];
    end
  end

  assign rs1_cnt = pend_q[rs1_idx];
  assign rs2_cnt = pend_q[rs2_idx];
  assign rd_cnt  = pend_q[rd_idx];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: RAW scoreboard at DE, mispredict redirect from AGEX,
// front-of-pipe freeze during multi-cycle MEM ops.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NumRegs     = NumRegsDefault,
  parameter int unsigned RegIdxW     = RegIdxWDefault,
  parameter int unsigned PcW         = PcWDefault,
  parameter int unsigned CntW        = CntWDefault,
  parameter int unsigned FlushCycles = FlushCyclesDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               de_valid,
  input  logic [RegIdxW-1:0] de_rs1,
  input  logic [RegIdxW-1:0] de_rs2,
  input  logic               de_rs1_use,
  input  logic               de_rs2_use,
  input  logic               de_wr_en,
  input  logic [RegIdxW-1:0] de_rd,
  input  logic               agex_br_mispred,
  input  logic [PcW-1:0]     agex_br_target,
  input  logic               mem_busy,
  input  logic               wb_wr_en,
  input  logic [RegIdxW-1:0] wb_rd,
  output logic               fe_stall,
  output logic               de_stall,
  output logic               agex_stall,
  output logic               de_bubble,
  output logic               fe_flush,
  output logic               de_flush,
  output logic               pc_redirect,
  output logic [PcW-1:0]     pc_redirect_target,
  output logic               data_hazard,
  output logic               control_hazard,
  output logic [NumRegs-1:0] busy_mask
);

  localparam int unsigned FlushCntW = $clog2(FlushCycles + 1);

  state_e               state_q, state_d;
  logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CntW-1:0]      rs1_cnt, rs2_cnt, rd_cnt;
  logic [NumRegs-1:0]   sb_mask;
  logic                 retire, issue;
  logic                 rs1_hz, rs2_hz, rd_full, hazard;
  ctrl_t                ctrl, ctrl_out;

  assign retire = wb_wr_en && (wb_rd != '0);

  // A last pending write retiring this cycle is visible through the regfile.
  assign rs1_hz = de_rs1_use && (de_rs1 != '0) && (rs1_cnt != '0) &&
                  !((rs1_cnt == CntW'(1)) && retire && (wb_rd == de_rs1));
  assign rs2_hz = de_rs2_use && (de_rs2 != '0) && (rs2_cnt != '0) &&
                  !((rs2_cnt == CntW'(1)) && retire && (wb_rd == de_rs2));
  assign rd_full = de_wr_en && (rd_cnt == {CntW{1'b1}});
  assign hazard  = de_valid && (rs1_hz || rs2_hz || rd_full);

  assign issue = de_valid && de_wr_en && (de_rd != '0) &&
                 !ctrl.de_stall && !ctrl.de_flush && !ctrl.de_bubble;

  reg_scoreboard #(
    .NumRegs(NumRegs),
    .RegIdxW(RegIdxW),
    .CntW   (CntW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (issue),
    .inc_idx  (de_rd),
    .dec_en   (retire),
    .dec_idx  (wb_rd),
    .rs1_idx  (de_rs1),
    .rs2_idx  (de_rs2),
    .rd_idx   (de_rd),
    .rs1_cnt  (rs1_cnt),
    .rs2_cnt  (rs2_cnt),
    .rd_cnt   (rd_cnt),
    .busy_mask(sb_mask)
  );

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    ctrl             = '0;
    ctrl.data_hazard = hazard;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d = StMemWait;
          // A RAW reader must not slip into AGEX on the way into the freeze.
          if (hazard) begin
            ctrl.fe_stall  = 1'b1;
            ctrl.de_stall  = 1'b1;
            ctrl.de_bubble = 1'b1;
          end
        end else if (agex_br_mispred) begin
          ctrl.pc_redirect = 1'b1;
          ctrl.fe_flush    = 1'b1;
          ctrl.de_flush    = 1'b1;
          flush_cnt_d      = FlushCntW'(FlushCycles);
          state_d          = StFlush;
        end else if (hazard) begin
          ctrl.fe_stall  = 1'b1;
          ctrl.de_stall  = 1'b1;
          ctrl.de_bubble = 1'b1;
        end
      end
      StFlush: begin
        ctrl.de_bubble = 1'b1;
        if (mem_busy) begin
          ctrl.fe_stall   = 1'b1;
          ctrl.de_stall   = 1'b1;
          ctrl.agex_stall = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FlushCntW'(1)) begin
            state_d = StRun;
          end
        end
      end
      StMemWait: begin
        ctrl.fe_stall   = 1'b1;
        ctrl.de_stall   = 1'b1;
        ctrl.agex_stall = 1'b1;
        if (!mem_busy) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    ctrl.control_hazard = ctrl.pc_redirect || (state_q == StFlush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Combinational outputs are forced low for the whole reset window.
  assign ctrl_out = reset ? '0 : ctrl;

  assign fe_stall           = ctrl_out.fe_stall;
  assign de_stall           = ctrl_out.de_stall;
  assign agex_stall         = ctrl_out.agex_stall;
  assign de_bubble          = ctrl_out.de_bubble;
  assign fe_flush           = ctrl_out.fe_flush;
  assign de_flush           = ctrl_out.de_flush;
  assign pc_redirect        = ctrl_out.pc_redirect;
  assign data_hazard        = ctrl_out.data_hazard;
  assign control_hazard     = ctrl_out.control_hazard;
  assign pc_redirect_target = ctrl_out.pc_redirect ? agex_br_target : '0;
  assign busy_mask          = reset ? '0 : sb_mask;

endmodule
